coprocessor0_regs: RTL
======================

# coprocessor0_regs

- System-control coprocessor (CP0) register bank and exception sequencer for the MIPS core.
- Sits directly downstream of the coprocessor control unit: it consumes that unit's MFC0/MTC0/RFE/unknown-COP0 strobes.
- Also takes exception and interrupt sources from the execute stage. It holds Status, Cause, EPC and PRId, and decides when an exception is taken.
- Drives the PC-redirect signals.

## Interface
- DATA_WIDTH, 32: register and bus width
- HW_IRQ_WIDTH, 6: external interrupt lines
- EXC_VECTOR, 32'h8000_0080: general exception vector
- PRID_VALUE, 32'h0000_0200: read-only PRId contents
- i_clk  in  1  system clock; all state updates on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  instruction in stage is valid; no exception, write or RFE takes effect without it
- i_copr_re  in  1  MFC0 strobe
- i_copr_we  in  1  MTC0 strobe
- i_eret  in  1  RFE strobe
- i_copr_wr_instr  in  1  unrecognised COP0 instruction; raises reserved-instruction exception
- i_addr  in  5  CP0 register number (rd field)
- i_wdata  in  DATA_WIDTH  MTC0 data
- i_pc  in  DATA_WIDTH  PC of instruction in stage
- i_exc_sys  in  1  syscall
- i_exc_ov  in  1  arithmetic overflow
- i_hw_irq  in  HW_IRQ_WIDTH  asynchronous interrupt levels
- o_rdata  out  DATA_WIDTH  MFC0 data, combinational; 0 when i_copr_re low or address unimplemented
- o_exc_taken  out  1  exception taken this cycle, combinational
- o_exc_vector  out  DATA_WIDTH  constant EXC_VECTOR
- o_eret_taken  out  1  RFE committed this cycle
- o_epc  out  DATA_WIDTH  current EPC register; RFE redirect target

## Operation
- **Status (12)**
  - [5:0] = KUo IEo KUp IEp KUc IEc; [15:8] = IM.
  - Other bits read 0.
  - Fully writable by MTC0 in [15:8] and [5:0].
- **Cause (13)**
  - [6:2] = ExcCode.
  - [15:10] = synchronized hardware IP; IP7 ([15]) is also ORed with the timer.
  - [9:8] = software IP, the only MTC0-writable bits.
  - Other bits read 0.
- **EPC (14)**: written only by exception entry; MTC0 to EPC is ignored. **PRId (15)**: read-only.
- Unimplemented addresses: writes ignored, reads 0.
- i_hw_irq passes through a 2-flop synchronizer before reaching Cause.
- Interrupt pending = Status.IEc & |(Cause[15:8] & Status[15:8]).
- Exception evaluated only when i_valid. Priority:
  1. interrupt, ExcCode 0
  2. reserved instruction (i_copr_wr_instr), ExcCode 10
  3. syscall, ExcCode 8
  4. overflow, ExcCode 12
- On exception, at the clock edge:
  - EPC <= i_pc
  - Cause.ExcCode <= code
  - Status[5:0] <= {Status[3:0], 2'b00}
- RFE committed (i_valid & i_eret & ~o_exc_taken): Status[3:0] <= Status[5:2]; Status[5:4] unchanged.
- Exception in the same cycle as MTC0 or RFE: the exception wins, and the write/RFE is dropped.

## Timing
- Reset values:
  - Status, Cause, EPC: all 0.
  - Synchronizer flops: 0.
  - COUNT 0, COMPARE all-ones, timer flag 0.
  - Outputs follow from these: o_exc_taken 0, o_eret_taken 0, o_epc 0.
- MTC0 is visible to MFC0 on the next cycle; same-cycle read returns the old value.
- Hardware IRQ to Cause.IP: 2 cycles. o_exc_taken can assert in the cycle after the IP bit is set, given IEc, IM and i_valid.
- Reset assertion mid-operation clears all state immediately, with no pending exception retained.

## Configuration
- **COPR_TIMER_EN defined**
  - COUNT (9) increments every cycle, wraps at 2^32, and is writable; the write takes precedence over the increment.
  - COMPARE (11) is writable; a write clears the timer flag.
  - The flag sets on the edge where COUNT == COMPARE (pre-increment value) and drives Cause[15] together with synchronized i_hw_irq[5].
- **COPR_TIMER_EN undefined**: registers 9/11 read 0 and ignore writes; Cause[15] = synchronized i_hw_irq[5] only.

## Structure
- Shared local_params/package holds:
  - CP0 register numbers (9, 11, 12, 13, 14, 15)
  - ExcCode values (0, 8, 10, 12)
  - Status/Cause bit positions and EXC_VECTOR default
- One sub-module, irq_sync: a parameterized 2-flop synchronizer with async active-low reset, instantiated once at HW_IRQ_WIDTH.

## Test plan
- **Syscall entry:** Status=0x0000_0001, i_valid=1, i_exc_sys=1, i_pc=0x400 → o_exc_taken=1 that cycle; next cycle EPC=0x400, Cause[6:2]=8, Status[5:0]=0b000100.
- **RFE:** RFE with Status[5:0]=0b000100 → o_eret_taken=1; next cycle Status[5:0]=0b000001; o_epc unchanged.
- **Hardware interrupt:** Status=0x0000_0401, i_hw_irq[0] rises → Cause[10]=1 after 2 cycles; o_exc_taken with ExcCode 0 on the next valid instruction. With IEc=0, no exception is taken.
- **Priority and dropped write:** interrupt, syscall and MTC0 Status=0 in the same cycle → ExcCode 0; the MTC0 is dropped and Status shifts per the exception rule.
- **Read-only and software IP:** MTC0 to EPC and PRId ignored; MTC0 Cause=0xFFFF_FFFF → reads back 0x0000_0300 (hardware IP bits 0).
- **Timer (COPR_TIMER_EN):** after reset, MTC0 COMPARE=10 → Cause[15] sets when COUNT reaches 10; MTC0 COMPARE=50 clears it.

Source files
------------

// File: rtl/coprocessor0_regs_pkg.sv
// coprocessor0_regs_pkg: shared CP0 register numbers, ExcCodes, bit positions and defaults
package coprocessor0_regs_pkg;
   localparam logic [4:0] CP0_COUNT   = 5'd9;
   localparam logic [4:0] CP0_COMPARE = 5'd11;
   localparam logic [4:0] CP0_STATUS  = 5'd12;
   localparam logic [4:0] CP0_CAUSE   = 5'd13;
   localparam logic [4:0] CP0_EPC     = 5'd14;
   localparam logic [4:0] CP0_PRID    = 5'd15;

   typedef enum logic [4:0] {
      EXC_INT = 5'd0,
      EXC_SYS = 5'd8,
      EXC_RI  = 5'd10,
      EXC_OV  = 5'd12
   } exc_code_e;

   localparam int ST_IEC      = 0;
   localparam int ST_IM_LSB   = 8;
   localparam int CA_EXC_LSB  = 2;
   localparam int CA_SWIP_LSB = 8;
   localparam int CA_HWIP_LSB = 10;

   localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0080;
   localparam logic [31:0] PRID_DEF       = 32'h0000_0200;

   // Fixed exception priority: interrupt > reserved instruction > syscall > overflow
   function automatic exc_code_e exc_code_sel(input logic irq, input logic ri, input logic sys);
      return irq ? EXC_INT : ri ? EXC_RI : sys ? EXC_SYS : EXC_OV;
   endfunction
endpackage

// File: rtl/coprocessor0_regs_if.sv
// coprocessor0_regs_if: strobe/data bus between the coprocessor control unit and the CP0 bank
// master = control unit / execute stage (drives i_*), slave = CP0 bank (drives o_*)
interface coprocessor0_regs_if #(parameter int DATA_WIDTH = 32);
   logic                  i_valid;
   logic                  i_copr_re;
   logic                  i_copr_we;
   logic                  i_eret;
   logic                  i_copr_wr_instr;
   logic [4:0]            i_addr;
   logic [DATA_WIDTH-1:0] i_wdata;
   logic [DATA_WIDTH-1:0] i_pc;
   logic                  i_exc_sys;
   logic                  i_exc_ov;
   logic [DATA_WIDTH-1:0] o_rdata;
   logic                  o_exc_taken;
   logic [DATA_WIDTH-1:0] o_exc_vector;
   logic                  o_eret_taken;
   logic [DATA_WIDTH-1:0] o_epc;

   modport master (
      output i_valid, i_copr_re, i_copr_we, i_eret, i_copr_wr_instr, i_addr, i_wdata, i_pc,
             i_exc_sys, i_exc_ov,
      input  o_rdata, o_exc_taken, o_exc_vector, o_eret_taken, o_epc
   );
   modport slave (
      input  i_valid, i_copr_re, i_copr_we, i_eret, i_copr_wr_instr, i_addr, i_wdata, i_pc,
             i_exc_sys, i_exc_ov,
      output o_rdata, o_exc_taken, o_exc_vector, o_eret_taken, o_epc
   );
endinterface

// File: rtl/coprocessor0_regs_irq_sync.sv
// irq_sync: two-flop synchronizer for asynchronous interrupt levels
// Ports: i_clk, i_rst_n (async active-low), i_d (async levels), o_q (synchronized levels)
module irq_sync #(parameter int WIDTH = 6) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end

   assign o_q = r_sync;
endmodule

// File: rtl/coprocessor0_regs.sv
// coprocessor0_regs: CP0 Status/Cause/EPC/PRId bank and exception sequencer
// Ports: i_clk, i_rst_n (async active-low), i_hw_irq (async interrupt levels),
//        bus (coprocessor0_regs_if.slave: MFC0/MTC0/RFE strobes, exception sources, redirect outputs)
// Optional COUNT/COMPARE timer enabled by defining COPR_TIMER_EN
module coprocessor0_regs
   import coprocessor0_regs_pkg::*;
#(
   parameter int              DATA_WIDTH   = 32,
   parameter int              HW_IRQ_WIDTH = 6,
   parameter logic [31:0]     EXC_VECTOR   = EXC_VECTOR_DEF,
   parameter logic [31:0]     PRID_VALUE   = PRID_DEF
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [HW_IRQ_WIDTH-1:0] i_hw_irq,
   coprocessor0_regs_if.slave      bus
);
   logic [5:0]            r_ku;
   logic [7:0]            r_im;
   exc_code_e             r_exc_code;
   logic [1:0]            r_sw_ip;
   logic [DATA_WIDTH-1:0] r_epc;

   logic [HW_IRQ_WIDTH-1:0] w_irq_sync;
   logic [5:0]              w_hw_ip;
   logic [7:0]              w_ip;
   logic                    w_timer;
   logic                    w_int;
   logic                    w_exc;
   logic                    w_wr;
   logic                    w_rfe;
   exc_code_e               w_code;
   logic [DATA_WIDTH-1:0]   w_status;
   logic [DATA_WIDTH-1:0]   w_cause;
   logic [DATA_WIDTH-1:0]   w_count_rd;
   logic [DATA_WIDTH-1:0]   w_compare_rd;

   irq_sync #(.WIDTH(HW_IRQ_WIDTH)) u_irq_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_hw_irq),
      .o_q     (w_irq_sync)
   );

   // IP7 is shared between the external line and the timer flag
   assign w_hw_ip = {w_irq_sync[5] | w_timer, w_irq_sync[4:0]};
   assign w_ip    = {w_hw_ip, r_sw_ip};
   assign w_int   = r_ku[ST_IEC] & |(w_ip & r_im);
   assign w_exc   = bus.i_valid & (w_int | bus.i_copr_wr_instr | bus.i_exc_sys | bus.i_exc_ov);
   assign w_code  = exc_code_sel(w_int, bus.i_copr_wr_instr, bus.i_exc_sys);
   // A taken exception squashes any MTC0 or RFE in the same instruction
   assign w_wr    = bus.i_valid & bus.i_copr_we & ~w_exc;
   assign w_rfe   = bus.i_valid & bus.i_eret & ~w_exc;

   always_comb begin
      w_status = '0;
      w_status[ST_IM_LSB +: 8] = r_im;
      w_status[5:0] = r_ku;
      w_cause = '0;
      w_cause[CA_HWIP_LSB +: 6] = w_hw_ip;
      w_cause[CA_SWIP_LSB +: 2] = r_sw_ip;
      w_cause[CA_EXC_LSB +: 5] = r_exc_code;
   end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_ku       <= '0;
         r_im       <= '0;
         r_exc_code <= EXC_INT;
         r_sw_ip    <= '0;
         r_epc      <= '0;
      end else if (w_exc) begin
         r_epc      <= bus.i_pc;
         r_exc_code <= w_code;
         r_ku       <= {r_ku[3:0], 2'b00};
      end else begin
         if (w_wr && bus.i_addr == CP0_STATUS) begin
            r_im <= bus.i_wdata[ST_IM_LSB +: 8];
            r_ku <= bus.i_wdata[5:0];
         end else if (w_rfe)
            r_ku[3:0] <= r_ku[5:2];
         if (w_wr && bus.i_addr == CP0_CAUSE)
            r_sw_ip <= bus.i_wdata[CA_SWIP_LSB +: 2];
      end

`ifdef COPR_TIMER_EN
   logic [DATA_WIDTH-1:0] r_count;
   logic [DATA_WIDTH-1:0] r_compare;
   logic                  r_timer_flag;

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_count      <= '0;
         r_compare    <= '1;
         r_timer_flag <= 1'b0;
      end else begin
         r_count <= (w_wr && bus.i_addr == CP0_COUNT) ? bus.i_wdata : r_count + 1'b1;
         // A COMPARE write acknowledges the timer even if a match lands on the same edge
         if (w_wr && bus.i_addr == CP0_COMPARE) begin
            r_compare    <= bus.i_wdata;
            r_timer_flag <= 1'b0;
         end else if (r_count == r_compare)
            r_timer_flag <= 1'b1;
      end

   assign w_timer      = r_timer_flag;
   assign w_count_rd   = r_count;
   assign w_compare_rd = r_compare;
`else
   assign w_timer      = 1'b0;
   assign w_count_rd   = '0;
   assign w_compare_rd = '0;
`endif

   assign bus.o_rdata = !bus.i_copr_re               ? '0 :
                        bus.i_addr == CP0_STATUS     ? w_status :
                        bus.i_addr == CP0_CAUSE      ? w_cause :
                        bus.i_addr == CP0_EPC        ? r_epc :
                        bus.i_addr == CP0_PRID       ? DATA_WIDTH'(PRID_VALUE) :
                        bus.i_addr == CP0_COUNT      ? w_count_rd :
                        bus.i_addr == CP0_COMPARE    ? w_compare_rd : '0;

   assign bus.o_exc_taken  = w_exc;
   assign bus.o_exc_vector = DATA_WIDTH'(EXC_VECTOR);
   assign bus.o_eret_taken = w_rfe;
   assign bus.o_epc        = r_epc;
endmodule
